// File: rtl/crack_sched.sv
// crack_sched: search controller for the brute-force password datapath.
// Loads and steps the ASCII decimal candidate generator and deals candidates
// round-robin to NUM_CORES hash/compare cores. It captures the first matching
// candidate, drains the work still in flight, and reports the result.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, start_data   begin-search pulse and first candidate
//   gen_load_n/gen_next generator load (active low) and advance strobe
//   gen_value           current generator candidate
//   core_valid/core_data per-core dispatch strobe and shared candidate bus
//   core_ready/core_done/core_match  per-core status from the cores
//   busy, found, result, tried_count  status to the UI/LCD logic
module crack_sched #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [63:0]          start_data,
   output logic                 gen_load_n,
   output logic                 gen_next,
   input  logic [63:0]          gen_value,
   output logic [NUM_CORES-1:0] core_valid,
   output logic [63:0]          core_data,
   input  logic [NUM_CORES-1:0] core_ready,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_match,
   output logic                 busy,
   output logic                 found,
   output logic [63:0]          result,
   output logic [CNT_W-1:0]     tried_count
);

   localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned SUM_W = PTR_W + 1;
   localparam int unsigned INC_W = $clog2(NUM_CORES + 1);
   localparam logic [63:0] LAST_CAND = 64'h3939_3939_3939_3939;  // "99999999"

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic [NUM_CORES-1:0] r_inflight;
   logic [PTR_W-1:0]     r_rr_ptr;
   logic                 r_exhausted;
   logic                 r_found;
   logic [63:0]          r_result;
   logic [CNT_W-1:0]     r_count;
   logic [63:0]          r_slot [NUM_CORES];

   logic [NUM_CORES-1:0] w_done_v;
   logic [NUM_CORES-1:0] w_hit;
   logic [NUM_CORES-1:0] w_avail;
   logic [NUM_CORES-1:0] w_rot;
   logic [NUM_CORES-1:0] w_grant;
   logic                 w_any;
   logic [PTR_W-1:0]     w_sel;
   logic [PTR_W-1:0]     w_next_ptr;
   logic                 w_dispatch;
   logic                 w_last;
   logic [63:0]          w_match_data;
   logic [INC_W-1:0]     w_inc;
   logic [CNT_W:0]       w_sum;

   // Reduce a pointer sum (at most 2N-2) back into 0..N-1.
   function automatic logic [PTR_W-1:0] f_wrap(input logic [SUM_W-1:0] v);
      logic [SUM_W-1:0] t;
      t = v;
      if (t >= SUM_W'(NUM_CORES)) t = t - SUM_W'(NUM_CORES);
      return PTR_W'(t);
   endfunction

   // Only completions of cores actually in flight count or can match.
   assign w_done_v = core_done & r_inflight;
   assign w_hit    = w_done_v & core_match;
   assign w_avail  = core_ready & ~r_inflight;
   assign w_last   = (gen_value == LAST_CAND);

   // Rotate availability so bit 0 corresponds to rr_ptr, then take the lowest set bit.
   assign w_rot = NUM_CORES'({w_avail, w_avail} >> r_rr_ptr);

   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_any = 1'b1;
            w_sel = f_wrap(SUM_W'(r_rr_ptr) + SUM_W'(k));
         end
      end
   end

   assign w_next_ptr = f_wrap(SUM_W'(w_sel) + SUM_W'(1));
   // A match arriving in RUN suppresses the dispatch of that same cycle.
   assign w_dispatch = (r_state == S_RUN) && !r_exhausted && !(|w_hit) && w_any;
   assign w_grant    = w_dispatch ? (NUM_CORES'(1) << w_sel) : '0;

   // Lowest-index matching core wins when several match together.
   always_comb begin
      w_match_data = '0;
      for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
         if (w_hit[k]) w_match_data = r_slot[k];
      end
   end

   // Popcount of valid completions, added with saturation.
   always_comb begin
      w_inc = '0;
      for (int k = 0; k < int'(NUM_CORES); k++) begin
         w_inc = w_inc + INC_W'(w_done_v[k]);
      end
      w_sum = {1'b0, r_count} + (CNT_W + 1)'(w_inc);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_state_nxt = S_LOAD;
         S_LOAD:         w_state_nxt = S_RUN;
         S_RUN:
            if ((|w_hit) || (w_dispatch && w_last) || r_exhausted) w_state_nxt = S_DRAIN;
         S_DRAIN:
            if ((r_inflight & ~w_done_v) == '0) w_state_nxt = S_DONE;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   // Search datapath: in-flight tracking, slots, pointer, result and count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight  <= '0;
         r_rr_ptr    <= '0;
         r_exhausted <= 1'b0;
         r_found     <= 1'b0;
         r_result    <= '0;
         r_count     <= '0;
         for (int k = 0; k < int'(NUM_CORES); k++) r_slot[k] <= '0;
      end else if (r_state == S_LOAD) begin
         r_inflight  <= '0;
         r_exhausted <= 1'b0;
         r_found     <= 1'b0;
         r_result    <= '0;
         r_count     <= '0;
      end else begin
         r_inflight <= (r_inflight & ~w_done_v) | w_grant;
         r_count    <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
         if ((|w_hit) && !r_found) begin
            r_found  <= 1'b1;
            r_result <= w_match_data;
         end
         if (w_dispatch) begin
            r_rr_ptr <= w_next_ptr;
            if (w_last) r_exhausted <= 1'b1;
         end
         for (int k = 0; k < int'(NUM_CORES); k++) begin
            if (w_grant[k]) r_slot[k] <= gen_value;
         end
      end
   end

   assign gen_load_n  = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_DONE);
   assign busy        = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN);
   assign gen_next    = w_dispatch;
   assign core_valid  = w_grant;
   assign core_data   = gen_value;
   assign found       = r_found;
   assign result      = r_result;
   assign tried_count = r_count;

endmodule

// File: tb/tb_crack_sched.sv
// tb_crack_sched: directed bench for crack_sched with an ASCII counter generator
// model and a simple per-core model (fixed latency or hand-driven completions).
module tb_crack_sched;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [63:0] start_data;
   logic        gen_load_n, gen_next;
   logic [63:0] gen_value = '0;
   logic [3:0]  core_valid, core_ready, core_done, core_match;
   logic [63:0] core_data;
   logic        busy, found;
   logic [63:0] result;
   logic [31:0] tried_count;

   int n_cmp = 0;
   int n_mis = 0;

   // core model state
   int          lat;            // 0: completions driven by hand
   logic [63:0] target;
   logic [3:0]  mask, man_done, man_match, mbusy;
   int          cnt [4];
   logic [63:0] mdata [4];
   int          d_core [$];
   logic [63:0] d_data [$];

   crack_sched #(.NUM_CORES(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .start_data(start_data),
      .gen_load_n(gen_load_n), .gen_next(gen_next), .gen_value(gen_value),
      .core_valid(core_valid), .core_data(core_data), .core_ready(core_ready),
      .core_done(core_done), .core_match(core_match), .busy(busy), .found(found),
      .result(result), .tried_count(tried_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] asc(input int unsigned n);
      logic [63:0] r;
      int unsigned v;
      v = n;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = 8'h30 + 8'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] asc_inc(input logic [63:0] v);
      logic [63:0] r;
      logic        carry;
      r = v;
      carry = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (carry) begin
            if (r[8*i +: 8] == 8'h39) r[8*i +: 8] = 8'h30;
            else begin
               r[8*i +: 8] = r[8*i +: 8] + 8'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Candidate generator: loads while gen_load_n is low, wraps after "99999999".
   always @(posedge clk) begin
      if (!gen_load_n)  gen_value <= start_data;
      else if (gen_next) gen_value <= asc_inc(gen_value);
   end

   // One clock cycle: drive core inputs, log dispatches, advance to next negedge.
   task automatic cyc();
      logic [3:0] d, m;
      d = man_done;
      m = man_match;
      for (int i = 0; i < 4; i++) begin
         if (lat != 0 && mbusy[i]) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
               d[i] = 1'b1;
               m[i] = (mdata[i] == target);
            end
         end
         if (d[i]) mbusy[i] = 1'b0;
      end
      core_done  = d;
      core_match = m;
      core_ready = mask & ~mbusy;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (core_valid[i]) begin
            mbusy[i] = 1'b1;
            cnt[i]   = lat;
            mdata[i] = core_data;
            d_core.push_back(i);
            d_data.push_back(core_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic model_clear();
      mbusy = '0; man_done = '0; man_match = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      d_core.delete();
      d_data.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      model_clear();
   endtask

   // Pulse start for one cycle (IDLE/DONE -> LOAD), then the LOAD cycle.
   task automatic start_search(input logic [63:0] data);
      start_data = data;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
   endtask

   task automatic run_until_idle(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         cyc();
         n++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", tag, busy, n);
         n_mis++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_mis++; end
      n_cmp++; if (gen_load_n !== 1'b0) begin $display("FAIL rst_load_n: got %b want 0", gen_load_n); n_mis++; end
      n_cmp++; if (gen_next !== 1'b0) begin $display("FAIL rst_next: got %b want 0", gen_next); n_mis++; end
      n_cmp++; if (core_valid !== 4'b0) begin $display("FAIL rst_valid: got %b want 0000", core_valid); n_mis++; end
      n_cmp++; if (found !== 1'b0) begin $display("FAIL rst_found: got %b want 0", found); n_mis++; end
      n_cmp++; if (result !== 64'h0) begin $display("FAIL rst_result: got %h want 0", result); n_mis++; end
      n_cmp++; if (tried_count !== 32'd0) begin $display("FAIL rst_count: got %0d want 0", tried_count); n_mis++; end
   endtask

   task automatic test_basic_match();
      lat = 3; mask = 4'b1111; target = asc(5);
      start_data = asc(0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || gen_load_n !== 1'b0) begin
         $display("FAIL load_state: got busy=%b load_n=%b want 1/0", busy, gen_load_n); n_mis++; end
      cyc();
      run_until_idle("basic");
      n_cmp++; if (found !== 1'b1) begin $display("FAIL basic_found: got %b want 1", found); n_mis++; end
      n_cmp++; if (result !== asc(5)) begin $display("FAIL basic_result: got %h want %h", result, asc(5)); n_mis++; end
      n_cmp++; if (tried_count !== 32'd8) begin $display("FAIL basic_count: got %0d want 8", tried_count); n_mis++; end
      n_cmp++; if (gen_load_n !== 1'b1) begin $display("FAIL basic_done_state: load_n=%b want 1", gen_load_n); n_mis++; end
      n_cmp++; if (d_core.size() != 8) begin $display("FAIL basic_ndisp: got %0d want 8", d_core.size()); n_mis++; end
      else begin
         n_cmp++; if (d_data[7] !== asc(7) || d_core[7] != 3) begin
            $display("FAIL basic_lastdisp: got core %0d data %h want core 3 data %h", d_core[7], d_data[7], asc(7)); n_mis++; end
      end
   endtask

   task automatic test_exhaust();
      model_clear();
      lat = 3; mask = 4'b1111; target = asc(12345678);
      start_search(asc(99999997));
      run_until_idle("exhaust");
      n_cmp++; if (d_core.size() != 3) begin $display("FAIL exh_ndisp: got %0d want 3", d_core.size()); n_mis++; end
      else begin
         n_cmp++; if (d_data[2] !== asc(99999999)) begin $display("FAIL exh_lastdisp: got %h want %h", d_data[2], asc(99999999)); n_mis++; end
      end
      n_cmp++; if (gen_value !== asc(0)) begin $display("FAIL exh_genwrap: got %h want %h", gen_value, asc(0)); n_mis++; end
      n_cmp++; if (found !== 1'b0) begin $display("FAIL exh_found: got %b want 0", found); n_mis++; end
      n_cmp++; if (result !== 64'h0) begin $display("FAIL exh_result: got %h want 0", result); n_mis++; end
      n_cmp++; if (tried_count !== 32'd3) begin $display("FAIL exh_count: got %0d want 3", tried_count); n_mis++; end
   endtask

   task automatic test_multi_match();
      model_clear();
      lat = 0; mask = 4'b1111;
      start_search(asc(10));
      for (int i = 0; i < 6; i++) cyc();
      // rr_ptr was left at 3: cores 3,0,1,2 get 10,11,12,13
      n_cmp++; if (d_core.size() != 4) begin $display("FAIL mm_ndisp: got %0d want 4", d_core.size()); n_mis++; end
      man_done = 4'b1010; man_match = 4'b1010;
      cyc();
      man_done = '0; man_match = '0;
      n_cmp++; if (result !== asc(12)) begin $display("FAIL mm_result: got %h want %h", result, asc(12)); n_mis++; end
      n_cmp++; if (found !== 1'b1) begin $display("FAIL mm_found: got %b want 1", found); n_mis++; end
      n_cmp++; if (tried_count !== 32'd2) begin $display("FAIL mm_count: got %0d want 2", tried_count); n_mis++; end
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL mm_drain: busy=%b want 1", busy); n_mis++; end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || gen_load_n !== 1'b1 || found !== 1'b1) begin
         $display("FAIL mm_start_in_drain: got busy=%b load_n=%b found=%b want 1/1/1", busy, gen_load_n, found); n_mis++; end
      man_done = 4'b0101; man_match = 4'b0101;
      cyc();
      man_done = '0; man_match = '0;
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL mm_done: busy=%b want 0", busy); n_mis++; end
      n_cmp++; if (result !== asc(12)) begin $display("FAIL mm_keep_result: got %h want %h", result, asc(12)); n_mis++; end
      n_cmp++; if (tried_count !== 32'd4) begin $display("FAIL mm_count2: got %0d want 4", tried_count); n_mis++; end
   endtask

   task automatic test_ready_rr();
      int exp_rr [5];
      exp_rr = '{0, 1, 2, 3, 0};
      do_reset();
      lat = 3; mask = 4'b0100; target = asc(12345678);
      start_search(asc(20));
      for (int i = 0; i < 9; i++) cyc();
      n_cmp++; if (d_core.size() != 3) begin $display("FAIL rdy_ndisp: got %0d want 3", d_core.size()); n_mis++; end
      foreach (d_core[i]) begin
         n_cmp++; if (d_core[i] != 2) begin $display("FAIL rdy_core%0d: got %0d want 2", i, d_core[i]); n_mis++; end
      end
      do_reset();
      lat = 3; mask = 4'b1111;
      start_search(asc(40));
      for (int i = 0; i < 5; i++) cyc();
      n_cmp++; if (d_core.size() != 5) begin $display("FAIL rr_ndisp: got %0d want 5", d_core.size()); n_mis++; end
      for (int i = 0; i < 5 && i < d_core.size(); i++) begin
         n_cmp++; if (d_core[i] != exp_rr[i]) begin $display("FAIL rr_order%0d: got %0d want %0d", i, d_core[i], exp_rr[i]); n_mis++; end
      end
      n_cmp++; if (d_data.size() == 5 && d_data[4] !== asc(44)) begin $display("FAIL rr_data4: got %h want %h", d_data[4], asc(44)); n_mis++; end
   endtask

   task automatic test_reset_in_run();
      do_reset();
      lat = 0; mask = 4'b0111;
      start_search(asc(50));
      for (int i = 0; i < 4; i++) cyc();
      n_cmp++; if (d_core.size() != 3) begin $display("FAIL rir_ndisp: got %0d want 3", d_core.size()); n_mis++; end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || gen_load_n !== 1'b1) begin
         $display("FAIL rir_start_in_run: got busy=%b load_n=%b want 1/1", busy, gen_load_n); n_mis++; end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_cmp++; if (busy !== 1'b0 || gen_load_n !== 1'b0) begin
         $display("FAIL rir_idle: got busy=%b load_n=%b want 0/0", busy, gen_load_n); n_mis++; end
      n_cmp++; if (core_valid !== 4'b0 || gen_next !== 1'b0) begin
         $display("FAIL rir_strobes: got valid=%b next=%b want 0000/0", core_valid, gen_next); n_mis++; end
      n_cmp++; if (found !== 1'b0 || result !== 64'h0 || tried_count !== 32'd0) begin
         $display("FAIL rir_status: got found=%b result=%h count=%0d want 0/0/0", found, result, tried_count); n_mis++; end
      model_clear();
      cyc();
      n_cmp++; if (busy !== 1'b0 || gen_load_n !== 1'b0) begin
         $display("FAIL rir_stay_idle: got busy=%b load_n=%b want 0/0", busy, gen_load_n); n_mis++; end
   endtask

   task automatic test_spurious_done();
      model_clear();
      lat = 0; mask = 4'b0010;
      start_search(asc(30));
      cyc();
      n_cmp++; if (d_core.size() != 1 || d_core[0] != 1) begin $display("FAIL sp_first: ndisp=%0d want 1 on core 1", d_core.size()); n_mis++; end
      man_done = 4'b0001; man_match = 4'b0001;
      cyc();
      man_done = '0; man_match = '0;
      n_cmp++; if (tried_count !== 32'd0) begin $display("FAIL sp_count: got %0d want 0", tried_count); n_mis++; end
      n_cmp++; if (found !== 1'b0 || busy !== 1'b1) begin $display("FAIL sp_found: got found=%b busy=%b want 0/1", found, busy); n_mis++; end
      man_done = 4'b0010; man_match = 4'b0000;
      cyc();
      man_done = '0;
      n_cmp++; if (tried_count !== 32'd1) begin $display("FAIL sp_real_count: got %0d want 1", tried_count); n_mis++; end
      n_cmp++; if (d_core.size() != 1) begin $display("FAIL sp_same_cycle_redisp: ndisp=%0d want 1", d_core.size()); n_mis++; end
      cyc();
      n_cmp++; if (d_core.size() != 2 || d_data[d_data.size()-1] !== asc(31)) begin
         $display("FAIL sp_redisp: ndisp=%0d want 2 with data %h", d_core.size(), asc(31)); n_mis++; end
      do_reset();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_data = '0;
      core_ready = '0; core_done = '0; core_match = '0;
      lat = 0; mask = '0; target = '0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_basic_match();
      test_exhaust();
      test_multi_match();
      test_ready_rr();
      test_reset_in_run();
      test_spurious_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
